// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment driver with frame-synchronous input snapshot,
// anode ghosting guard, leading-zero blanking and selectable output polarity.
module seg_scan_driver #(
  parameter int SCAN_DIV   = 50000,
  parameter int GHOST      = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  input  logic [3:0] d,
  input  logic [3:0] e,
  input  logic [3:0] f,
  input  logic       en,
  input  logic [5:0] dp_mask,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int   CW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_slot;
  logic [5:0][3:0] r_snap;      // index 0 = digit a (leftmost)
  logic [5:0]      r_snap_dp;   // bit 5 = digit a
  logic            r_frame_tick;
  logic [5:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;

  logic            w_cnt_last;
  logic            w_frame_end;
  logic            w_anode_on;
  logic [5:0]      w_lead_zero;
  logic [3:0]      w_digit;
  logic            w_blank;
  logic            w_dp_sel;
  logic [5:0]      w_an_sel;
  logic [6:0]      w_seg_pat;
  logic [5:0]      w_an;
  logic [6:0]      w_seg;
  logic            w_dp;

  assign w_cnt_last  = (r_cnt == CW'(SCAN_DIV - 1));
  assign w_frame_end = w_cnt_last && (r_slot == 3'd5);
  assign w_anode_on  = en && (int'(r_cnt) >= GHOST);

  // Digit k is a leading zero when it and every digit to its left are zero.
  always_comb begin
    w_lead_zero = '0;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) w_lead_zero[k] = (r_snap[k] == 4'd0);
      else        w_lead_zero[k] = (r_snap[k] == 4'd0) && w_lead_zero[k-1];
    end
  end

  always_comb begin
    w_digit  = '0;
    w_blank  = 1'b0;
    w_dp_sel = 1'b0;
    w_an_sel = '0;
    for (int k = 0; k < 6; k++) begin
      if (r_slot == 3'(k)) begin
        w_digit       = r_snap[k];
        w_blank       = w_lead_zero[k] && (k != 5);
        w_dp_sel      = r_snap_dp[5-k];
        w_an_sel[5-k] = 1'b1;
      end
    end
  end

  // Active-high patterns, bit order gfedcba.
  always_comb begin
    w_seg_pat = 7'b1000000;
    case (w_digit)
      4'd0: w_seg_pat = 7'b0111111;
      4'd1: w_seg_pat = 7'b0000110;
      4'd2: w_seg_pat = 7'b1011011;
      4'd3: w_seg_pat = 7'b1001111;
      4'd4: w_seg_pat = 7'b1100110;
      4'd5: w_seg_pat = 7'b1101101;
      4'd6: w_seg_pat = 7'b1111101;
      4'd7: w_seg_pat = 7'b0000111;
      4'd8: w_seg_pat = 7'b1111111;
      4'd9: w_seg_pat = 7'b1101111;
      default: w_seg_pat = 7'b1000000;
    endcase
  end

  always_comb begin
    w_an  = w_anode_on ? w_an_sel : 6'd0;
    w_seg = (en && !w_blank) ? w_seg_pat : 7'd0;
    w_dp  = w_anode_on && w_dp_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_slot       <= '0;
      r_snap       <= '0;
      r_snap_dp    <= '0;
      r_frame_tick <= 1'b0;
      r_an         <= {6{POL}};
      r_seg        <= {7{POL}};
      r_dp         <= POL;
    end else begin
      r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
      if (w_cnt_last) r_slot <= (r_slot == 3'd5) ? 3'd0 : r_slot + 3'd1;
      // Inputs are captured only at frame end so a frame never mixes old and new data.
      if (w_frame_end) begin
        r_snap    <= {f, e, d, c, b, a};
        r_snap_dp <= dp_mask;
      end
      r_frame_tick <= w_frame_end;
      r_an         <= w_an ^ {6{POL}};
      r_seg        <= w_seg ^ {7{POL}};
      r_dp         <= w_dp ^ POL;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles per digit slot; SCAN_DIV SHALL be > GHOST+1.
REQ-002 Parameter GHOST, default 2, cycles at slot start during which all anodes SHALL be inactive.
REQ-003 Parameter ACTIVE_LOW, default 1; 1 SHALL mean an, seg and dp are driven active-low, 0 active-high.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 a, b, c, d, e, f  input  4 each  BCD digits; a is most significant (leftmost), f least significant.
REQ-007 en  input  1  display enable.
REQ-008 dp_mask  input  6  decimal-point request; bit 5 = digit a ... bit 0 = digit f.
REQ-009 an  output  6  one-hot digit select; an[5] = digit a ... an[0] = digit f.
REQ-010 seg  output  7  segments; seg[0] = segment a ... seg[6] = segment g.
REQ-011 dp  output  1  decimal point of the selected digit.
REQ-012 frame_tick  output  1  one-cycle pulse marking the start of a frame that uses new snapshot data.

Function
REQ-013 Prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; slot SHALL advance 0..5 and wrap to 0 in the cycle cnt wraps.
REQ-014 Slot k SHALL select digit a,b,c,d,e,f for k=0..5 respectively, and anode an[5-k].
REQ-015 Snapshot registers SHALL load a..f and dp_mask only in the cycle where cnt==SCAN_DIV-1 and slot==5; input changes at any other time SHALL NOT affect the display until that load (no mid-frame tearing).
REQ-016 frame_tick SHALL be registered and high for exactly the one cycle after each snapshot load; it SHALL stay 0 otherwise.
REQ-017 an, seg and dp SHALL be registered from the same-cycle cnt, slot, snapshot and en, giving exactly one cycle of latency.
REQ-018 While cnt < GHOST, all anodes SHALL be inactive; otherwise exactly one anode, an[5-slot], SHALL be active.
REQ-019 Active-high segment patterns, gfedcba: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-020 Codes 10-15 SHALL display a dash, meaning only segment g is lit (active-high 1000000).
REQ-021 Leading-zero blanking: a snapshot digit SHALL be blanked (all segments inactive) when it is 0 and every more-significant snapshot digit is 0; digit f SHALL never be blanked.
REQ-022 A non-zero invalid code (10-15) SHALL count as non-zero for blanking purposes.
REQ-023 dp SHALL be active iff the snapshot dp_mask bit for the current slot is 1 and the anode is active; blanking SHALL NOT suppress dp.
REQ-024 With en=0, an, seg and dp SHALL be inactive one cycle later, while cnt, slot, snapshot and frame_tick continue unaffected.
REQ-025 ACTIVE_LOW SHALL invert an, seg and dp at the output registers only; internal logic SHALL be polarity-independent.

Reset
REQ-026 reset SHALL take priority over all other inputs in any cycle, including mid-slot or mid-frame.
REQ-027 On reset: cnt=0, slot=0, snapshot digits=0, snapshot dp_mask=0, frame_tick=0, and an/seg/dp all inactive.
REQ-028 The first frame after reset SHALL display snapshot zeros: digits a-e blanked, digit f showing '0'.

Verification (SCAN_DIV=4, GHOST=1, ACTIVE_LOW=1)
REQ-029 Reset held for 3 cycles -> an=111111, seg=1111111, dp=1, frame_tick=0; after release, the first frame shows an[0] active with seg=1000000 ('0').
REQ-030 Inputs a..f=1,2,3,4,5,6 held for 2 frames -> in the second frame: slot 0 an=011111, seg=1111001; slot 5 an=111110, seg=0000010; frame_tick pulses once per 24 cycles.
REQ-031 Inputs a..f=0,0,0,0,0,7 with dp_mask=000010 -> slots 0-4 give seg=1111111; slot 4 gives dp=0; slot 5 gives seg=1111000.
REQ-032 Input c=4'hC, with all other digits 0 -> digit c seg=0111111, digits a and b blanked, digits d and e show '0'.
REQ-033 Inputs changed at slot 2 of a frame -> remaining slots of that frame are unchanged; new values appear in the slot immediately after the next frame_tick.
REQ-034 en dropped for 10 cycles mid-slot -> an=111111 from the next cycle; on en=1, display resumes at the current slot/cnt position with no prescaler reset.
